// File: rtl/adder_if.sv
// Operand/result bundle for the 32-bit lookahead adder.
// The master drives operands and carry-in; the slave returns sum and carry-out.
interface adder_if;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        car_in;
  logic [31:0] result;
  logic        car_out;

  modport master (
    output a_in,
    output b_in,
    output car_in,
    input  result,
    input  car_out
  );

  modport slave (
    input  a_in,
    input  b_in,
    input  car_in,
    output result,
    output car_out
  );
endinterface

// File: rtl/adder.sv
// Combinational 32-bit two-level carry-lookahead adder: eight 4-bit groups
// feed a second-level unit that computes every group carry in flat form.
module adder (
  input  logic   clk,
  input  logic   rst_n,
  adder_if.slave bus
);

  // Flat sum-of-products carry after n stages:
  // OR over j<n of g[j] & p[j+1..n-1], plus cin & p[0..n-1].
  function automatic logic cla_carry(
    input logic [7:0] g,
    input logic [7:0] p,
    input logic       cin,
    input int         n
  );
    logic c;
    logic t;
    c = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j < n) begin
        t = g[j];
        for (int m = 0; m < 8; m++) begin
          if (m > j && m < n) t = t & p[m];
        end
        c = c | t;
      end
    end
    t = cin;
    for (int m = 0; m < 8; m++) begin
      if (m < n) t = t & p[m];
    end
    return c | t;
  endfunction

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;
  logic [7:0]  w_grp_g;
  logic [7:0]  w_grp_p;
  logic [8:0]  w_grp_c;
  logic        w_unused;

  // Clock and reset are present only for port uniformity.
  assign w_unused = clk & rst_n;

  assign w_g = bus.a_in & bus.b_in;
  assign w_p = bus.a_in ^ bus.b_in;

  genvar gi;
  genvar bi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_group
      assign w_grp_g[gi] = cla_carry({4'b0, w_g[4*gi +: 4]}, {4'b0, w_p[4*gi +: 4]}, 1'b0, 4);
      assign w_grp_p[gi] = &w_p[4*gi +: 4];
      for (bi = 0; bi < 4; bi++) begin : g_bit
        assign w_c[4*gi + bi] = cla_carry({4'b0, w_g[4*gi +: 4]}, {4'b0, w_p[4*gi +: 4]},
                                          w_grp_c[gi], bi);
      end
    end

    // Second level: carry into each group, and car_out as the ninth term.
    for (gi = 0; gi < 9; gi++) begin : g_top
      assign w_grp_c[gi] = cla_carry(w_grp_g, w_grp_p, bus.car_in, gi);
    end
  endgenerate

  assign bus.result  = w_p ^ w_c;
  assign bus.car_out = w_grp_c[8];

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: corner-case table, field sweeps, random
// vectors against a plain-arithmetic model, and a clock/reset toggle check.
module tb_adder;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  adder_if bus ();

  adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] res;
    logic        cout;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    return {1'b0, a} + {1'b0, b} + {32'b0, cin};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
    bus.a_in   = a;
    bus.b_in   = b;
    bus.car_in = cin;
  endtask

  task automatic check(input string name, input logic [31:0] er, input logic ec,
                       input bit verbose);
    n_total++;
    if (bus.result === er && bus.car_out === ec) begin
      n_pass++;
      if (verbose)
        $display("ok   %s: a=%08h b=%08h cin=%0b -> result=%08h car_out=%0b",
                 name, bus.a_in, bus.b_in, bus.car_in, bus.result, bus.car_out);
    end else begin
      $display("FAIL %s: a=%08h b=%08h cin=%0b got result=%08h car_out=%0b want result=%08h car_out=%0b",
               name, bus.a_in, bus.b_in, bus.car_in, bus.result, bus.car_out, er, ec);
    end
  endtask

  // 16-bit field sweep with stride 17 (hits both 0000 and ffff).
  task automatic sweep(input bit on_b, input int sh, input bit desc);
    logic [31:0] base;
    logic [31:0] mask;
    logic [31:0] field;
    logic [32:0] s;
    int          v;
    int          pass0;
    int          tot0;
    pass0 = n_pass;
    tot0  = n_total;
    base  = desc ? 32'hffff_ffff : 32'h0;
    mask  = 32'h0000_ffff << sh;
    for (int i = 0; i <= 65535; i += 17) begin
      v     = desc ? 65535 - i : i;
      field = (base & ~mask) | (32'(v) << sh);
      if (on_b) drive(base, field, desc);
      else      drive(field, base, desc);
      #2;
      s = ref_sum(bus.a_in, bus.b_in, bus.car_in);
      check($sformatf("sweep_%s_sh%0d_%s", on_b ? "b" : "a", sh, desc ? "down" : "up"),
            s[31:0], s[32], 1'b0);
      #2;
    end
    $display("sweep %s[%0d+:16] %s: %0d/%0d steps matched",
             on_b ? "b_in" : "a_in", sh, desc ? "descending" : "ascending",
             n_pass - pass0, n_total - tot0);
  endtask

  initial begin
    logic [32:0] s;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [31:0] ones;

    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    drive(32'h0, 32'h0, 1'b0);

    tbl[0]  = '{"zero",          32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    tbl[1]  = '{"all_ones_cin",  32'hffff_ffff, 32'hffff_ffff, 1'b1, 32'hffff_ffff, 1'b1};
    tbl[2]  = '{"full_prop",     32'hffff_ffff, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    tbl[3]  = '{"grp_3_4",       32'h0000_000f, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0};
    tbl[4]  = '{"byte_bound",    32'h0000_00ff, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    tbl[5]  = '{"half_bound",    32'h0000_ffff, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0};
    tbl[6]  = '{"bit24_cin",     32'h00ff_ffff, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0};
    tbl[7]  = '{"grp_27_28",     32'h0fff_ffff, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0};
    tbl[8]  = '{"signed_wrap",   32'h7fff_ffff, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
    tbl[9]  = '{"msb_carry",     32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    tbl[10] = '{"sub_5_3",       32'h0000_0005, 32'hffff_fffc, 1'b1, 32'h0000_0002, 1'b1};
    tbl[11] = '{"sub_3_5",       32'h0000_0003, 32'hffff_fffa, 1'b1, 32'hffff_fffe, 1'b0};
    tbl[12] = '{"alt_bits",      32'haaaa_aaaa, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1};
    tbl[13] = '{"mixed",         32'h1234_5678, 32'h9abc_def0, 1'b0, 32'hacf1_3568, 1'b0};

    // Outputs must track inputs even while reset is asserted.
    #2;
    check("in_reset_zero", 32'h0, 1'b0, 1'b1);
    drive(32'h0000_0001, 32'h0000_0002, 1'b1);
    #2;
    check("in_reset_add", 32'h0000_0004, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].a, tbl[i].b, tbl[i].cin);
      #1;
      check(tbl[i].name, tbl[i].res, tbl[i].cout, 1'b1);
    end

    // Carry rippling into each group boundary from car_in alone.
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      ones = (32'h1 << (4 * k)) - 32'h1;
      drive(ones, 32'h0, 1'b1);
      #1;
      check($sformatf("cin_to_grp%0d", k), 32'h1 << (4 * k), 1'b0, 1'b1);
    end

    @(negedge clk);
    for (int sh = 16; sh >= 0; sh -= 8) sweep(1'b0, sh, 1'b0);
    for (int sh = 16; sh >= 0; sh -= 8) sweep(1'b1, sh, 1'b0);
    for (int sh = 16; sh >= 0; sh -= 8) sweep(1'b0, sh, 1'b1);
    for (int sh = 16; sh >= 0; sh -= 8) sweep(1'b1, sh, 1'b1);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      drive(ra, rb, rc);
      #1;
      s = ref_sum(ra, rb, rc);
      check($sformatf("rand_%0d", i), s[31:0], s[32], 1'b1);
    end

    // Clock and reset activity must not disturb the sum.
    @(negedge clk);
    drive(32'h1234_5678, 32'h9abc_def0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #3;
      rst_n = ~rst_n;
      #1;
      check($sformatf("rst_toggle_%0d", i), 32'hacf1_3568, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("clk_edge_%0d", i), 32'hacf1_3568, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
